kbd_scan: RTL and testbench

KBD_SCAN -- requirements
Module: kbd_scan

---
 rtl/kbd_scan.sv | 186 ++++++++++++++++++
 tb/tb_kbd_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan.sv
// kbd_scan: 4x4 matrix keyboard scanner with frame-based debounce,
// make/break event FIFO and a small register interface.
module kbd_scan #(
    parameter int unsigned CLK_DIV    = 1000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic [3:0] key_col,
    input  logic [3:0] key_row,
    output logic       irq
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t         state_q, state_d;
    logic           ctrl_en, ctrl_irq;
    logic [3:0]     dbn;
    logic [15:0]    presc;
    logic [1:0]     col;
    logic [15:0]    raw, last_frame, stable, committed;
    logic [3:0]     match;
    logic           ovf;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;

    logic           wr_en, slot_end, frame_end, push, pop, full, push_ok, empty;
    logic [3:0]     sample, n_eff, match_next, emit_idx;
    logic [15:0]    frame_raw, stable_next, diff;
    logic [7:0]     event_code;
    logic           unused_di;

    assign unused_di = ^DI[7:4];

    // Datapath decode: bus strobes, debounce arithmetic and next event selection
    always_comb begin
        wr_en      = cs & ~rw;
        empty      = (count == '0);
        full       = (count == CW'(FIFO_DEPTH));
        pop        = cs & rw & (AD == 3'd1) & ~empty;
        slot_end   = (state_q == SCAN) && ctrl_en && (presc == 16'(CLK_DIV - 1));
        frame_end  = slot_end && (col == 2'd3);
        sample     = ~key_row;
        // The last column is still in flight at frame end, so splice it in here.
        frame_raw  = {sample, raw[11:0]};
        n_eff      = (dbn == 4'd0) ? 4'd1 : dbn;
        if (frame_raw == last_frame)
            match_next = (match == 4'd15) ? 4'd15 : match + 4'd1;
        else
            match_next = 4'd1;
        stable_next = (match_next >= n_eff) ? frame_raw : stable;
        diff        = stable ^ committed;
        emit_idx    = 4'd0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (diff[i-1])
                emit_idx = 4'(i - 1);
        end
        event_code = {stable[emit_idx], 3'b000, emit_idx};
        push       = (state_q == EMIT) && ctrl_en && (diff != '0);
        push_ok    = push && (!full || pop);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state and column drive
    always_comb begin
        state_d = state_q;
        key_col = 4'b1111;
        case (state_q)
            IDLE: if (ctrl_en) state_d = SCAN;
            SCAN: begin
                key_col = ~(4'b0001 << col);
                if (frame_end && (stable_next != committed))
                    state_d = EMIT;
            end
            EMIT: if (diff == '0) state_d = SCAN;
            default: state_d = IDLE;
        endcase
        if (!ctrl_en)
            state_d = IDLE;
    end

    // Registers, scan counters, debounce state and FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en    <= 1'b0;
            ctrl_irq   <= 1'b0;
            dbn        <= 4'd3;
            presc      <= '0;
            col        <= '0;
            raw        <= '0;
            last_frame <= '0;
            stable     <= '0;
            committed  <= '0;
            match      <= '0;
            ovf        <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_en) begin
                case (AD)
                    3'd0: if (DI[1]) ovf <= 1'b0;
                    3'd2: begin
                        ctrl_en  <= DI[0];
                        ctrl_irq <= DI[1];
                    end
                    3'd3: dbn <= DI[3:0];
                    default: ;
                endcase
            end

            if (state_q == IDLE) begin
                presc <= '0;
                col   <= '0;
            end else if (state_q == SCAN && ctrl_en) begin
                if (slot_end) begin
                    presc <= '0;
                    col   <= col + 2'd1;
                    raw[{col, 2'b00} +: 4] <= sample;
                end else begin
                    presc <= presc + 16'd1;
                end
            end

            if (frame_end) begin
                last_frame <= frame_raw;
                match      <= match_next;
                stable     <= stable_next;
            end

            // A dropped event still retires its key so the FSM can make progress.
            if (push)
                committed[emit_idx] <= stable[emit_idx];
            if (push && full && !pop)
                ovf <= 1'b1;

            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);

            irq <= ctrl_irq & (~empty | ovf);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= event_code;
    end

    // Register read mux
    always_comb begin
        DO = 8'hFF;
        case (AD)
            3'd0: DO = {5'b00000, state_q != IDLE, ovf, ~empty};
            3'd1: DO = empty ? 8'hFF : mem[rd_ptr];
            3'd2: DO = {6'b000000, ctrl_irq, ctrl_en};
            3'd3: DO = {4'b0000, dbn};
            default: DO = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_kbd_scan.sv
// tb_kbd_scan: directed checks of kbd_scan with a behavioural key matrix.
module tb_kbd_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic       irq;

    logic [15:0] pressed;
    logic [15:0] keys;
    logic        toggle_en;
    logic        tog0 = 1'b0;
    logic [3:0]  prev_col = 4'hF;
    logic [3:0]  exp_col;
    logic [7:0]  rdata;
    logic        found;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kbd_scan #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .AD      (AD),
        .DI      (DI),
        .DO      (DO),
        .rw      (rw),
        .cs      (cs),
        .key_col (key_col),
        .key_row (key_row),
        .irq     (irq)
    );

    assign keys = pressed | {15'b0, tog0};

    // Key matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!key_col[c] && keys[4*c+r])
                    key_row[r] = 1'b0;
    end

    // Flip key 0 once per frame, at the start of column 1
    always @(negedge clk) begin
        prev_col <= key_col;
        if (!toggle_en)
            tog0 <= 1'b0;
        else if (key_col == 4'b1101 && prev_col == 4'b1110)
            tog0 <= ~tog0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(tag, {24'b0, d}, {24'b0, exp});
    endtask

    task automatic wait_event(input string tag, input int limit);
        logic [7:0] d;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            rd(3'd0, d);
            if (d[0]) found = 1'b1;
        end
        check(tag, {31'b0, found}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
        pressed = 16'h0000; toggle_en = 1'b0;
        #23;
        check("rst_col", {28'b0, key_col}, 32'hF);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        rd_chk("reg0", 3'd0, 8'h00);
        rd_chk("reg1", 3'd1, 8'hFF);
        rd_chk("reg2", 3'd2, 8'h00);
        rd_chk("reg3", 3'd3, 8'h03);
        rd_chk("reg5", 3'd5, 8'hFF);
        check("idle_col", {28'b0, key_col}, 32'hF);

        // Column walk with no keys
        wr(3'd2, 8'h03);
        for (int k = 0; k < 10 && key_col == 4'hF; k++)
            @(negedge clk);
        check("col_start", {28'b0, key_col}, 32'hE);
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            check("col_walk", {28'b0, key_col}, {28'b0, exp_col});
            @(negedge clk);
        end
        rd_chk("nokey_stat", 3'd0, 8'h04);

        // Key 6 with three-frame debounce
        wr(3'd2, 8'h00);
        pressed = 16'h0040;
        wr(3'd2, 8'h03);
        repeat (40) @(negedge clk);
        rd_chk("early_stat", 3'd0, 8'h04);
        check("early_irq", {31'b0, irq}, 32'd0);
        wait_event("k6_make_wait", 30);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'd1);
        rd_chk("k6_make", 3'd1, 8'h86);
        rd_chk("k6_only", 3'd1, 8'hFF);
        rd_chk("k6_stat", 3'd0, 8'h04);
        @(negedge clk);
        check("irq_clr", {31'b0, irq}, 32'd0);
        pressed = 16'h0000;
        wait_event("k6_brk_wait", 60);
        rd_chk("k6_break", 3'd1, 8'h06);

        // Keys 1 and 9 together
        pressed = 16'h0202;
        wait_event("k19_wait", 60);
        rd_chk("k1_make", 3'd1, 8'h81);
        rd_chk("k9_make", 3'd1, 8'h89);
        rd_chk("k19_empty", 3'd1, 8'hFF);
        pressed = 16'h0000;
        wait_event("k19_brk_wait", 60);
        rd_chk("k1_break", 3'd1, 8'h01);
        rd_chk("k9_break", 3'd1, 8'h09);

        // Bouncing key 0 never settles with N=2
        wr(3'd3, 8'h02);
        rd_chk("dbn2", 3'd3, 8'h02);
        toggle_en = 1'b1;
        repeat (200) @(negedge clk);
        toggle_en = 1'b0;
        repeat (48) @(negedge clk);
        rd_chk("bounce_stat", 3'd0, 8'h04);
        check("bounce_irq", {31'b0, irq}, 32'd0);

        // Overflow: five makes into a four-entry FIFO, N=0 acts as 1
        wr(3'd3, 8'h00);
        rd_chk("dbn0", 3'd3, 8'h00);
        wr(3'd2, 8'h00);
        pressed = 16'h001F;
        wr(3'd2, 8'h03);
        repeat (40) @(negedge clk);
        wr(3'd2, 8'h02);
        rd_chk("ovf_stat", 3'd0, 8'h03);
        check("ovf_irq", {31'b0, irq}, 32'd1);
        rd_chk("ovf_ev0", 3'd1, 8'h80);
        rd_chk("ovf_ev1", 3'd1, 8'h81);
        rd_chk("ovf_ev2", 3'd1, 8'h82);
        rd_chk("ovf_ev3", 3'd1, 8'h83);
        rd_chk("ovf_empty", 3'd1, 8'hFF);
        rd_chk("ovf_only", 3'd0, 8'h02);
        wr(3'd0, 8'h02);
        rd_chk("ovf_clr", 3'd0, 8'h00);
        @(negedge clk);
        check("ovf_irq_clr", {31'b0, irq}, 32'd0);

        // Asynchronous reset while scanning
        pressed = 16'h0001;
        wr(3'd2, 8'h03);
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        AD = 3'd2;
        #1;
        check("mid_rst_col", {28'b0, key_col}, 32'hF);
        check("mid_rst_ctrl", {24'b0, DO}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("post_rst_dbn", 3'd3, 8'h03);
        rd_chk("post_rst_stat", 3'd0, 8'h00);
        rd_chk("post_rst_data", 3'd1, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
